// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, state
// encodings, datapath steering codes and the control bundle type.
package main_fsm_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SEL_W   = 2;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LW  = 7'h03;
  localparam logic [OP_W-1:0] OP_I   = 7'h13;
  localparam logic [OP_W-1:0] OP_SW  = 7'h23;
  localparam logic [OP_W-1:0] OP_R   = 7'h33;
  localparam logic [OP_W-1:0] OP_BEQ = 7'h63;
  localparam logic [OP_W-1:0] OP_JAL = 7'h6F;

  // Controller states
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  // resultsrc codes
  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

  // alusrca codes
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  // alusrcb codes
  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  // aluop codes
  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  // immsrc codes
  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  // Per-cycle control bundle driven to the multicycle datapath
  typedef struct packed {
    logic             branch;
    logic             pcupdate;
    logic             regwrite;
    logic             memwrite;
    logic             irwrite;
    logic             adrsrc;
    logic [SEL_W-1:0] resultsrc;
    logic [SEL_W-1:0] alusrca;
    logic [SEL_W-1:0] alusrcb;
    logic [SEL_W-1:0] aluop;
    logic             illegal;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_imm_src_decoder.sv
// Immediate-format selector: maps opcode to immsrc.
// Ports: op (opcode in), immsrc (immediate format out, I for unknown ops).
// Independent of the instruction-class enables.
module main_fsm_imm_src_decoder
  import main_fsm_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [SEL_W-1:0] immsrc
);

  always_comb begin
    immsrc = IMM_I;
    case (op)
      OP_SW:   immsrc = IMM_S;
      OP_BEQ:  immsrc = IMM_B;
      OP_JAL:  immsrc = IMM_J;
      default: immsrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback
// over a shared memory port and ALU, with a mem_ready wait handshake.
// Ports: clk, reset (async active-high), op (opcode), mem_ready (access done)
//   -> branch, pcupdate, regwrite, memwrite, irwrite, adrsrc, resultsrc,
//      alusrca, alusrcb, aluop, immsrc, illegal, state (debug trace).
// Outputs are decoded from the state register so FETCH strobes can follow
// mem_ready within the same cycle.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter bit ENABLE_BRANCH = 1'b1,
  parameter bit ENABLE_JAL    = 1'b1,
  parameter bit MEM_WAIT      = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               branch,
  output logic               pcupdate,
  output logic               regwrite,
  output logic               memwrite,
  output logic               irwrite,
  output logic               adrsrc,
  output logic [SEL_W-1:0]   resultsrc,
  output logic [SEL_W-1:0]   alusrca,
  output logic [SEL_W-1:0]   alusrcb,
  output logic [SEL_W-1:0]   aluop,
  output logic [SEL_W-1:0]   immsrc,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   rdy;

  // With waits disabled every access completes in its first cycle
  assign rdy = mem_ready | ~MEM_WAIT;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and control decode
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURES;
        ctrl.irwrite   = rdy;
        ctrl.pcupdate  = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alusrca = SRCA_OLDPC;
        ctrl.alusrcb = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL: begin
            if (ENABLE_JAL) state_d = S_JAL;
            else begin
              ctrl.illegal = 1'b1;
              state_d      = S_FETCH;
            end
          end
          OP_BEQ: begin
            if (ENABLE_BRANCH) state_d = S_BEQ;
            else begin
              ctrl.illegal = 1'b1;
              state_d      = S_FETCH;
            end
          end
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
        case (op)
          OP_LW:   state_d = S_MEMREAD;
          OP_SW:   state_d = S_MEMWRITE;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMREAD: begin
        ctrl.adrsrc = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regwrite  = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.adrsrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.aluop   = ALUOP_FUNCT;
        state_d      = S_ALUWB;
      end
      S_EXECUTEI: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_FUNCT;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        ctrl.alusrca  = SRCA_OLDPC;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.pcupdate = 1'b1;
        state_d       = S_ALUWB;
      end
      S_BEQ: begin
        ctrl.alusrca = SRCA_RS1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.branch  = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // State is already FETCH during reset; only the write strobes need masking
    if (reset) begin
      ctrl.regwrite = 1'b0;
      ctrl.memwrite = 1'b0;
      ctrl.irwrite  = 1'b0;
      ctrl.pcupdate = 1'b0;
      ctrl.branch   = 1'b0;
      ctrl.illegal  = 1'b0;
    end
  end

  main_fsm_imm_src_decoder u_imm_src_decoder (
    .op     (op),
    .immsrc (immsrc)
  );

  assign branch    = ctrl.branch;
  assign pcupdate  = ctrl.pcupdate;
  assign regwrite  = ctrl.regwrite;
  assign memwrite  = ctrl.memwrite;
  assign irwrite   = ctrl.irwrite;
  assign adrsrc    = ctrl.adrsrc;
  assign resultsrc = ctrl.resultsrc;
  assign alusrca   = ctrl.alusrca;
  assign alusrcb   = ctrl.alusrcb;
  assign aluop     = ctrl.aluop;
  assign illegal   = ctrl.illegal;
  assign state     = STATE_W'(state_q);

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: two instances (all classes with waits, and branch/jal
// disabled without waits) checked cycle by cycle against a scoreboard of
// expected control vectors built from per-instruction state sequences.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready;

  logic       branch0, pcupdate0, regwrite0, memwrite0, irwrite0, adrsrc0, illegal0;
  logic [1:0] resultsrc0, alusrca0, alusrcb0, aluop0, immsrc0;
  logic [3:0] state0;
  logic       branch1, pcupdate1, regwrite1, memwrite1, irwrite1, adrsrc1, illegal1;
  logic [1:0] resultsrc1, alusrca1, alusrcb1, aluop1, immsrc1;
  logic [3:0] state1;

  always #5 clk = ~clk;

  main_fsm u_dut0 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .branch(branch0), .pcupdate(pcupdate0), .regwrite(regwrite0),
    .memwrite(memwrite0), .irwrite(irwrite0), .adrsrc(adrsrc0),
    .resultsrc(resultsrc0), .alusrca(alusrca0), .alusrcb(alusrcb0),
    .aluop(aluop0), .immsrc(immsrc0), .illegal(illegal0), .state(state0)
  );

  main_fsm #(.ENABLE_BRANCH(1'b0), .ENABLE_JAL(1'b0), .MEM_WAIT(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .branch(branch1), .pcupdate(pcupdate1), .regwrite(regwrite1),
    .memwrite(memwrite1), .irwrite(irwrite1), .adrsrc(adrsrc1),
    .resultsrc(resultsrc1), .alusrca(alusrca1), .alusrcb(alusrcb1),
    .aluop(aluop1), .immsrc(immsrc1), .illegal(illegal1), .state(state1)
  );

  wire [20:0] obs0 = {branch0, pcupdate0, regwrite0, memwrite0, irwrite0, adrsrc0,
                      resultsrc0, alusrca0, alusrcb0, aluop0, immsrc0, illegal0, state0};
  wire [20:0] obs1 = {branch1, pcupdate1, regwrite1, memwrite1, irwrite1, adrsrc1,
                      resultsrc1, alusrca1, alusrcb1, aluop1, immsrc1, illegal1, state1};

  logic       sel;
  wire [20:0] obs = sel ? obs1 : obs0;

  // Capabilities of the instance currently under check
  logic b_en, j_en, mw_en;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0] st;
    logic       drv;
    logic       eff;
    logic       ill;
  } step_t;

  logic [20:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] want);
    n_checks++;
    if (got !== want)
      $display("FAIL %s: got %h expected %h", tag, got, want);
    else
      n_pass++;
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      7'h23:   return 2'b01;
      7'h63:   return 2'b10;
      7'h6F:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Expected control vector for a state, from the state output table
  function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic [6:0] o,
                                          input logic rdy, input logic ill, input logic rst);
    logic br, pc, rw, mw, ir, ad;
    logic [1:0] rs, sa, sb, ao;
    br = 0; pc = 0; rw = 0; mw = 0; ir = 0; ad = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00;
    case (st)
      4'd0:  begin sb = 2'b10; rs = 2'b10; ir = rdy & ~rst; pc = rdy & ~rst; end
      4'd1:  begin sa = 2'b01; sb = 2'b01; end
      4'd2:  begin sa = 2'b10; sb = 2'b01; end
      4'd3:  ad = 1;
      4'd4:  begin rs = 2'b01; rw = 1; end
      4'd5:  begin ad = 1; mw = 1; end
      4'd6:  begin sa = 2'b10; ao = 2'b10; end
      4'd7:  rw = 1;
      4'd8:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      4'd9:  begin sa = 2'b01; sb = 2'b10; pc = 1; end
      4'd10: begin sa = 2'b10; ao = 2'b01; br = 1; end
      default: ;
    endcase
    return {br, pc, rw, mw, ir, ad, rs, sa, sb, ao, imm_of(o), ill, st};
  endfunction

  // Runs one instruction starting at a negedge in FETCH; returns at a negedge.
  // fw/mw: wait cycles in FETCH and in MEMREAD/MEMWRITE. ncyc>0 stops early.
  task automatic do_instr(input string name, input logic [6:0] o,
                          input int fw, input int mw, input int ncyc);
    step_t plan[$];
    step_t s;
    int    lim;
    if (mw_en) begin
      for (int i = 0; i < fw; i++) plan.push_back('{4'd0, 1'b0, 1'b0, 1'b0});
      plan.push_back('{4'd0, 1'b1, 1'b1, 1'b0});
    end else begin
      plan.push_back('{4'd0, 1'b0, 1'b1, 1'b0});
    end
    case (o)
      7'h03: begin
        plan.push_back('{4'd1, 1'b0, 1'b0, 1'b0});
        plan.push_back('{4'd2, 1'b0, 1'b0, 1'b0});
        if (mw_en) for (int i = 0; i < mw; i++) plan.push_back('{4'd3, 1'b0, 1'b0, 1'b0});
        plan.push_back('{4'd3, mw_en, 1'b1, 1'b0});
        plan.push_back('{4'd4, 1'b0, 1'b0, 1'b0});
      end
      7'h23: begin
        plan.push_back('{4'd1, 1'b0, 1'b0, 1'b0});
        plan.push_back('{4'd2, 1'b0, 1'b0, 1'b0});
        if (mw_en) for (int i = 0; i < mw; i++) plan.push_back('{4'd5, 1'b0, 1'b0, 1'b0});
        plan.push_back('{4'd5, mw_en, 1'b1, 1'b0});
      end
      7'h33: begin
        plan.push_back('{4'd1, 1'b0, 1'b0, 1'b0});
        plan.push_back('{4'd6, 1'b0, 1'b0, 1'b0});
        plan.push_back('{4'd7, 1'b0, 1'b0, 1'b0});
      end
      7'h13: begin
        plan.push_back('{4'd1, 1'b0, 1'b0, 1'b0});
        plan.push_back('{4'd8, 1'b0, 1'b0, 1'b0});
        plan.push_back('{4'd7, 1'b0, 1'b0, 1'b0});
      end
      default: begin
        if (o == 7'h6F && j_en) begin
          plan.push_back('{4'd1, 1'b0, 1'b0, 1'b0});
          plan.push_back('{4'd9, 1'b0, 1'b0, 1'b0});
          plan.push_back('{4'd7, 1'b0, 1'b0, 1'b0});
        end else if (o == 7'h63 && b_en) begin
          plan.push_back('{4'd1, 1'b0, 1'b0, 1'b0});
          plan.push_back('{4'd10, 1'b0, 1'b0, 1'b0});
        end else begin
          plan.push_back('{4'd1, 1'b0, 1'b0, 1'b1});
        end
      end
    endcase
    lim = (ncyc > 0 && ncyc < plan.size()) ? ncyc : plan.size();
    for (int i = 0; i < lim; i++) begin
      s  = plan[i];
      op = o;
      // mem_ready is don't-care outside wait states: randomise it there
      if (s.st == 4'd0 || s.st == 4'd3 || s.st == 4'd5) mem_ready = s.drv;
      else mem_ready = 1'($urandom_range(0, 1));
      exp_q.push_back(exp_vec(s.st, o, s.eff, s.ill, 1'b0));
      #1;
      check_eq($sformatf("%s cyc%0d", name, i), obs, exp_q.pop_front());
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 1'b0; b_en = 1'b1; j_en = 1'b1; mw_en = 1'b1;
    reset = 1'b1; op = 7'h00; mem_ready = 1'b1;
    #1;
    check_eq("reset dut0", obs0, exp_vec(4'd0, 7'h00, 1'b1, 1'b0, 1'b1));
    check_eq("reset dut1", obs1, exp_vec(4'd0, 7'h00, 1'b1, 1'b0, 1'b1));
    @(negedge clk); @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;

    // Full-featured instance with memory waits
    do_instr("lw_wait", 7'h03, 2, 1, 0);
    do_instr("sw",      7'h23, 0, 0, 0);
    do_instr("beq",     7'h63, 0, 0, 0);
    do_instr("jal",     7'h6F, 0, 0, 0);
    do_instr("r",       7'h33, 1, 0, 0);
    do_instr("i",       7'h13, 0, 0, 0);
    do_instr("ill7f",   7'h7F, 0, 0, 0);
    do_instr("ill00",   7'h00, 1, 0, 0);
    do_instr("sw_wait", 7'h23, 0, 2, 0);

    // Abandon a store mid-wait via async reset
    do_instr("sw_abort", 7'h23, 0, 3, 4);
    check_eq("pre_reset memwrite", obs0, exp_vec(4'd5, 7'h23, 1'b0, 1'b0, 1'b0));
    #2 reset = 1'b1;
    #1;
    check_eq("async reset", obs0, exp_vec(4'd0, 7'h23, 1'b0, 1'b0, 1'b1));
    mem_ready = 1'b1;
    #1;
    check_eq("reset masks irwrite", obs0, exp_vec(4'd0, 7'h23, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    do_instr("lw_after_rst", 7'h03, 2, 1, 0);
    do_instr("jal2", 7'h6F, 1, 0, 0);

    // Branch/jal disabled, waits ignored
    sel = 1'b1; b_en = 1'b0; j_en = 1'b0; mw_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    do_instr("nb_beq",  7'h63, 0, 0, 0);
    do_instr("nb_jal",  7'h6F, 0, 0, 0);
    do_instr("nw_7f",   7'h7F, 0, 0, 0);
    do_instr("nw_lw",   7'h03, 2, 2, 0);
    do_instr("nw_sw",   7'h23, 1, 3, 0);
    do_instr("nw_r",    7'h33, 0, 0, 0);
    do_instr("nw_i",    7'h13, 0, 0, 0);
    #1;
    check_eq("nw_end_fetch", obs1, exp_vec(4'd0, op, 1'b1, 1'b0, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
